// File: rtl/bnn_ocr_pkg.sv
// Shared constants and types for the BNN OCR front end.
// Image geometry and the pixel unpacker state encoding.
package bnn_ocr_pkg;

  localparam int IMG_DIM    = 28;
  localparam int IMG_PIXELS = IMG_DIM * IMG_DIM;
  localparam int BYTE_W     = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    SHIFT,
    DONE
  } unpack_state_t;

endpackage

// File: rtl/pixel_shift_reg.sv
// Byte-wide load / shift-left register for the pixel unpacker.
// Tracks how many pixels of the loaded byte are still pending.
module pixel_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb,
  output logic         empty,
  output logic         last
);

  localparam int BW = $clog2(W + 1);

  logic [W-1:0]  shreg;
  logic [BW-1:0] bits_left;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      shreg     <= '0;
      bits_left <= '0;
    end else if (load) begin
      shreg     <= din;
      bits_left <= BW'(W);
    end else if (shift && bits_left != '0) begin
      shreg     <= shreg << 1;
      bits_left <= bits_left - BW'(1);
    end
  end

  assign msb   = shreg[W-1];
  assign empty = bits_left == '0;
  assign last  = bits_left == BW'(1);

endmodule

// File: rtl/pixel_unpacker.sv
// Unpacks host bytes (MSB first) into single-pixel writes
// for the binary image store, with frame and error flags.
module pixel_unpacker #(
  parameter int IMG_PIXELS = bnn_ocr_pkg::IMG_PIXELS,
  parameter int BYTE_W     = bnn_ocr_pkg::BYTE_W,
  parameter int CNT_W      = $clog2(IMG_PIXELS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  input  logic [BYTE_W-1:0] s_data,
  output logic              s_ready,
  input  logic              buf_full,
  output logic              clear_buffer,
  output logic [BYTE_W-1:0] pix_data,
  output logic              pix_we,
  output logic [CNT_W-1:0]  pix_count,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow_err
);

  import bnn_ocr_pkg::*;

  unpack_state_t state;

  logic sr_msb;
  logic sr_empty;
  logic sr_last;
  logic in_shift;
  logic final_px;
  logic blocked;
  logic wr;
  logic hs;
  logic sr_clr;

  assign in_shift = state == SHIFT;
  assign final_px = pix_count == CNT_W'(IMG_PIXELS - 1);
  assign blocked  = buf_full && !final_px;

  // start and rst pre-empt the current pixel and any handshake
  assign wr = in_shift && !sr_empty && !blocked
              && !start && !rst;

  assign s_ready = !rst && !start
                   && (state == LOAD
                       || (in_shift && sr_last
                           && !final_px && !blocked));

  assign hs     = s_valid && s_ready;
  assign sr_clr = start
                  || (in_shift && blocked)
                  || (wr && final_px);

  pixel_shift_reg #(
    .W(BYTE_W)
  ) u_sr (
    .clk  (clk),
    .rst  (rst),
    .clr  (sr_clr),
    .load (hs),
    .shift(wr && !hs),
    .din  (s_data),
    .msb  (sr_msb),
    .empty(sr_empty),
    .last (sr_last)
  );

  assign pix_we       = wr;
  assign pix_data     = {{(BYTE_W-1){1'b0}}, wr && sr_msb};
  assign clear_buffer = state == CLEAR;
  assign busy         = state inside {CLEAR, LOAD, SHIFT};

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pix_count    <= '0;
      frame_done   <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (start) begin
        state        <= CLEAR;
        pix_count    <= '0;
        overflow_err <= 1'b0;
      end else begin
        unique case (state)
          CLEAR: begin
            state        <= LOAD;
            pix_count    <= '0;
            overflow_err <= 1'b0;
          end
          LOAD: begin
            if (hs) state <= SHIFT;
          end
          SHIFT: begin
            if (blocked) begin
              overflow_err <= 1'b1;
              state        <= DONE;
            end else if (wr) begin
              pix_count <= pix_count + CNT_W'(1);
              if (final_px) begin
                frame_done <= 1'b1;
                state      <= DONE;
              end else if (sr_last && !hs) begin
                state <= LOAD;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pixel_unpacker.sv
// Scoreboard bench for pixel_unpacker: accepted bytes become
// queued expected pixels that a negedge monitor pops and checks.
module tb_pixel_unpacker;

  localparam int NPIX = 784;

  logic       clk = 1'b0;
  logic       rst, start, s_valid, s_ready, buf_full;
  logic       clear_buffer, pix_we, busy;
  logic       frame_done, overflow_err;
  logic [7:0] s_data, pix_data;
  logic [9:0] pix_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pixel_unpacker dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .buf_full    (buf_full),
    .clear_buffer(clear_buffer),
    .pix_data    (pix_data),
    .pix_we      (pix_we),
    .pix_count   (pix_count),
    .busy        (busy),
    .frame_done  (frame_done),
    .overflow_err(overflow_err)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic fail_to(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out", nm);
  endtask

  // reference model: pending pixels of accepted bytes, frame totals
  bit q[$];
  int wr_cnt = 0, acc = 0, hs_cnt = 0, fd_cnt = 0;
  int clr_cyc = 0, cyc = 0, first_cyc = -1, last_cyc = -1;
  bit e_clr = 0, e_fd = 0, e_busy = 0, e_ovf = 0;
  bit n_clr, n_fd, exp_we, exp_rdy, bit_x;
  bit chk_on = 0;

  always @(negedge clk) begin
    cyc++;
    if (chk_on) begin
      chk("clear_buffer", clear_buffer, e_clr);
      chk("frame_done", frame_done, e_fd);
      chk("busy", busy, e_busy);
      chk("overflow_err", overflow_err, e_ovf);
      chk("pix_count", pix_count, wr_cnt);
    end
    if (clear_buffer) clr_cyc++;
    if (frame_done) fd_cnt++;
    n_clr = 0;
    n_fd  = 0;
    if (rst) begin
      q.delete();
      wr_cnt = 0;
      acc    = 0;
      e_busy = 0;
      e_ovf  = 0;
    end else if (start) begin
      chk("start_ready", s_ready, 0);
      chk("start_we", pix_we, 0);
      q.delete();
      wr_cnt    = 0;
      acc       = 0;
      n_clr     = 1;
      e_busy    = 1;
      e_ovf     = 0;
      first_cyc = -1;
    end else begin
      exp_we = q.size() > 0
               && !(buf_full && wr_cnt != NPIX - 1);
      chk("pix_we", pix_we, exp_we);
      if (exp_we) begin
        bit_x = q.pop_front();
        chk("pix_data", pix_data, {7'b0, bit_x});
        wr_cnt++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        if (wr_cnt == NPIX) begin
          n_fd   = 1;
          e_busy = 0;
        end
      end else if (q.size() > 0) begin
        e_ovf  = 1;
        e_busy = 0;
        q.delete();
      end
      exp_rdy = e_busy && !e_clr
                && q.size() == 0 && acc < NPIX;
      chk("s_ready", s_ready, exp_rdy);
      if (s_valid && s_ready) begin
        hs_cnt++;
        for (int k = 7; k >= 0; k--) q.push_back(s_data[k]);
        acc += 8;
      end
    end
    e_clr = n_clr;
    e_fd  = n_fd;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    if (gap > 0) begin
      s_valid = 1'b0;
      repeat (gap) tick();
    end
    s_valid = 1'b1;
    s_data  = b;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (s_ready) begin
        tick();
        return;
      end
      tick();
    end
    fail_to("handshake");
  endtask

  task automatic wait_idle(input string nm);
    for (int t = 0; t < 4000; t++) begin
      @(negedge clk);
      if (!busy) begin
        @(negedge clk);
        return;
      end
    end
    fail_to(nm);
  endtask

  int clr0, fd0, hs0;

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    s_valid  = 1'b0;
    s_data   = 8'h00;
    buf_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_on = 1;
    @(negedge clk);
    chk("por_busy", busy, 0);
    chk("por_cnt", pix_count, 0);
    tick();
    rst = 1'b0;

    // reset in the middle of a frame
    pulse_start();
    for (int i = 0; i < 3; i++) send(8'($urandom), 0);
    rst = 1'b1;
    tick();
    @(negedge clk);
    clr0 = clr_cyc;
    chk("rst_ready", s_ready, 0);
    chk("rst_clear", clear_buffer, 0);
    chk("rst_we", pix_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_ovf", overflow_err, 0);
    chk("rst_data", pix_data, 0);
    chk("rst_cnt", pix_count, 0);
    tick();
    tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("rst_no_clear", clr_cyc - clr0, 0);
    chk("idle_ready", s_ready, 0);
    s_valid = 1'b0;

    // gapless full frame of 0xA5
    clr0 = clr_cyc;
    fd0  = fd_cnt;
    pulse_start();
    for (int i = 0; i < 98; i++) send(8'hA5, 0);
    s_valid = 1'b0;
    wait_idle("frame_a5");
    chk("a5_pixels", wr_cnt, NPIX);
    chk("a5_contig", last_cyc - first_cyc + 1, NPIX);
    chk("a5_done", fd_cnt - fd0, 1);
    chk("a5_clear", clr_cyc - clr0, 1);
    chk("a5_count", pix_count, NPIX);

    // bytes offered after the frame are back-pressured
    hs0     = hs_cnt;
    s_valid = 1'b1;
    s_data  = 8'hFF;
    repeat (20) tick();
    chk("post_accept", hs_cnt - hs0, 0);
    chk("post_pixels", wr_cnt, NPIX);
    chk("post_data", s_data, 8'hFF);
    s_valid = 1'b0;

    // gappy 0x80 bytes, then random bytes and gaps
    fd0 = fd_cnt;
    pulse_start();
    for (int i = 0; i < 10; i++) send(8'h80, 5);
    for (int i = 0; i < 88; i++)
      send(8'($urandom), $urandom_range(0, 3));
    s_valid = 1'b0;
    wait_idle("frame_gaps");
    chk("gap_pixels", wr_cnt, NPIX);
    chk("gap_done", fd_cnt - fd0, 1);

    // store fills after 100 pixels
    fd0 = fd_cnt;
    pulse_start();
    for (int i = 0; i < 13; i++) send(8'($urandom), 0);
    s_valid = 1'b0;
    begin
      bit hit = 0;
      for (int t = 0; t < 200 && !hit; t++) begin
        @(posedge clk);
        if (wr_cnt >= 100) hit = 1;
      end
      if (!hit) fail_to("wait_100");
    end
    #1;
    buf_full = 1'b1;
    s_valid  = 1'b1;
    s_data   = 8'($urandom);
    repeat (20) tick();
    chk("full_pixels", wr_cnt, 100);
    chk("full_ovf", overflow_err, 1);
    chk("full_done", fd_cnt - fd0, 0);
    chk("full_busy", busy, 0);
    s_valid  = 1'b0;
    buf_full = 1'b0;
    pulse_start();
    @(negedge clk);
    chk("ovf_cleared", overflow_err, 0);

    // start collides with a handshake after 300+ pixels
    for (int i = 0; i < 38; i++) send(8'($urandom), 0);
    repeat (7) tick();
    chk("abort_pre", wr_cnt, 303);
    clr0    = clr_cyc;
    fd0     = fd_cnt;
    hs0     = hs_cnt;
    s_valid = 1'b1;
    s_data  = 8'($urandom);
    start   = 1'b1;
    @(negedge clk);
    chk("abort_ready", s_ready, 0);
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("abort_cnt", pix_count, 0);
    chk("abort_clear", clear_buffer, 1);
    chk("abort_no_hs", hs_cnt - hs0, 0);
    for (int i = 0; i < 98; i++) send(8'($urandom), 0);
    s_valid = 1'b0;
    wait_idle("frame_after_abort");
    chk("abort_pixels", wr_cnt, NPIX);
    chk("abort_contig", last_cyc - first_cyc + 1, NPIX);
    chk("abort_done", fd_cnt - fd0, 1);
    chk("abort_clr_n", clr_cyc - clr0, 1);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

endmodule
